mips_exec_mem_core: RTL and testbench
=====================================

// Module: mips_exec_mem_core
// PURPOSE
//  Single-cycle decode/execute/memory slice for the 32-bit MIPS pipeline: main control decode,
//  3-bit ALU, and word-addressed data memory. Sits between the register file (rs/rt operands in)
//  and write-back (wb_data out). Only the memory array is sequential; everything else is combinational.
// PARAMETERS
//  MEM_DEPTH  256  data memory depth in 32-bit words (power of two)
//  ADDR_W     8    log2(MEM_DEPTH); word index = alu_result[ADDR_W+1:2]
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  instr        in   32  instruction word (opcode [31:26], funct [5:0], imm [15:0])
//  rs_data      in   32  register operand A
//  rt_data      in   32  register operand B; also the store data
//  reg_dst      out  1   1 = destination is rd (R-type), 0 = rt
//  reg_write    out  1   register-file write enable
//  alu_src      out  1   1 = ALU B is sign-extended imm, 0 = rt_data
//  mem_read     out  1   data memory read enable
//  mem_write    out  1   data memory write enable
//  mem_to_reg   out  1   1 = wb_data from memory, 0 = from ALU
//  branch       out  1   beq
//  jump         out  1   j
//  alu_control  out  3   ALU operation code
//  alu_result   out  32  ALU output; also the memory byte address
//  zero         out  1   alu_result == 0
//  mem_rdata    out  32  memory read data
//  wb_data      out  32  mem_to_reg ? mem_rdata : alu_result
// BEHAVIOUR
//  Decode (combinational). Flags listed as RD RW AS MR MW M2R BR J, then alu_control:
//   op 00 R-type:  1 1 0 0 0 0 0 0; funct 20 add=010, 22 sub=110, 24 and=000, 25 or=001, 2A slt=111
//   op 23 lw:      0 1 1 1 0 1 0 0, 010
//   op 2B sw:      0 0 1 0 1 0 0 0, 010
//   op 04 beq:     0 0 0 0 0 0 1 0, 110
//   op 08 addi:    0 1 1 0 0 0 0 0, 010
//   op 02 j:       0 0 0 0 0 0 0 1, 010
//   Any other opcode, or an unlisted R-type funct: all flags 0, alu_control=010.
//   Unknown encodings therefore never write the register file or memory.
//  ALU. A = rs_data; B = alu_src ? {{16{instr[15]}},instr[15:0]} : rt_data.
//   010 = A+B; 110 = A-B; both wrap mod 2^32, no overflow flag.
//   000 = A&B; 001 = A|B.
//   111 = signed(A) < signed(B) ? 1 : 0.
//   Other codes give 0. zero = (alu_result == 0).
//  Memory.
//   Write: synchronous. On rising clk with mem_write=1, mem[word index] <= rt_data.
//   Read: combinational. mem_rdata = mem_read ? mem[word index] : 0.
//   Addressing: addr[1:0] is ignored (no misalignment trap). Bits above ADDR_W+1 are ignored, so addresses wrap.
//   Read and write to the same word in one cycle: read returns the old data until the edge, then the new data.
//   If mem_read and mem_write are both 1, the write still occurs.
//  Reset. rst=0 asynchronously clears every memory word to 0 and blocks writes while low.
//   After reset, mem_rdata=0 for any address. Combinational outputs follow their inputs during reset.
//   Reset asserted mid-write: the write is lost; the word reads 0 after release.
//  Latency: decode, ALU and reads 0 cycles; writes become visible 1 edge after the cycle they are presented.
// TESTING
//  1 Reset: rst=0 then 1; lw (instr=8C000010), rs_data=0
//     -> mem_rdata=0, wb_data=0, mem_to_reg=1, alu_result=0x10.
//  2 R-type: add rs=7,rt=5 -> 12; sub 5-7 -> FFFFFFFE, zero=0; and F0F0&0FF0 -> 00F0;
//     or -> FFF0; slt FFFFFFFF,1 -> 1; reg_dst=1, reg_write=1.
//  3 addi imm=FFFC (-4), rs_data=10 -> alu_result=6, alu_src=1.
//     beq with rs=rt=9 -> alu_result=0, zero=1, branch=1, reg_write=0.
//  4 Store/load: sw (op 2B) rs=0x100, imm=4, rt=DEADBEEF; clock edge;
//     then lw same address -> mem_rdata=DEADBEEF, wb_data=DEADBEEF.
//     Address 0x107 reads the same word; 0x504 aliases 0x104 (MEM_DEPTH=256).
//  5 Illegal: opcode 3F or funct 3F -> all flags 0; after one edge, memory is unchanged.
//  6 Reset mid-run: write AAAA5555 to word 3, then pulse rst low between edges -> word 3 reads 0.

Source files
------------

// File: rtl/mips_exec_mem_core.sv
// Decode/execute/memory slice of a 32-bit MIPS pipeline: main control, 3-bit ALU and a
// word-addressed data memory with combinational read, synchronous write and async clear.
module mips_exec_mem_core #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic [2:0]  alu_control,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] mem_rdata,
  output logic [31:0] wb_data
);

  // {reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, alu_control}
  logic [10:0]       ctl;
  logic [31:0]       alu_b;
  logic [31:0]       imm_ext;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       mem_q [MEM_DEPTH];
  logic              unused_instr_bits;

  assign unused_instr_bits = ^{instr[25:16]};

  always_comb begin
    ctl = 11'b00000000_010;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h20:   ctl = 11'b11000000_010;
          6'h22:   ctl = 11'b11000000_110;
          6'h24:   ctl = 11'b11000000_000;
          6'h25:   ctl = 11'b11000000_001;
          6'h2A:   ctl = 11'b11000000_111;
          default: ctl = 11'b00000000_010;
        endcase
      end
      6'h23:   ctl = 11'b01110100_010;
      6'h2B:   ctl = 11'b00101000_010;
      6'h04:   ctl = 11'b00000010_110;
      6'h08:   ctl = 11'b01100000_010;
      6'h02:   ctl = 11'b00000001_010;
      default: ctl = 11'b00000000_010;
    endcase
  end

  assign {reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump} = ctl[10:3];
  assign alu_control = ctl[2:0];

  assign imm_ext = {{16{instr[15]}}, instr[15:0]};
  assign alu_b   = alu_src ? imm_ext : rt_data;

  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      3'b010:  alu_result = rs_data + alu_b;
      3'b110:  alu_result = rs_data - alu_b;
      3'b000:  alu_result = rs_data & alu_b;
      3'b001:  alu_result = rs_data | alu_b;
      3'b111:  alu_result = {31'd0, $signed(rs_data) < $signed(alu_b)};
      default: alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign word_idx = alu_result[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_write) begin
      mem_q[word_idx] <= rt_data;
    end
  end

  assign mem_rdata = mem_read ? mem_q[word_idx] : 32'd0;
  assign wb_data   = mem_to_reg ? mem_rdata : alu_result;

endmodule

// File: tb/tb_mips_exec_mem_core.sv
// Bench for mips_exec_mem_core: fixed vector table, hand-written memory/reset sequences,
// and randomized instructions checked against an abstract decode/ALU/memory model.
module tb_mips_exec_mem_core;

  logic        clk;
  logic        rst;
  logic [31:0] instr, rs_data, rt_data;
  logic        reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump;
  logic [2:0]  alu_control;
  logic [31:0] alu_result, mem_rdata, wb_data;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  mips_exec_mem_core #(.MEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump),
    .alu_control(alu_control), .alu_result(alu_result), .zero(zero),
    .mem_rdata(mem_rdata), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [10:0] ctl;
    logic [31:0] res;
    logic        z;
  } vec_t;

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_BAD} kind_t;

  logic [31:0] ref_mem [256];
  bit          pend_we;
  int          pend_idx;
  logic [31:0] pend_data;

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic kind_t classify(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h20) return K_ADD;
        if (ins[5:0] == 6'h22) return K_SUB;
        if (ins[5:0] == 6'h24) return K_AND;
        if (ins[5:0] == 6'h25) return K_OR;
        if (ins[5:0] == 6'h2A) return K_SLT;
        return K_BAD;
      end
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h08:   return K_ADDI;
      6'h02:   return K_J;
      default: return K_BAD;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one instruction, compares every output with the model, and queues any store.
  task automatic apply(input string name, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b);
    kind_t       k;
    bit          rd, rw, as, mr, mw, m2r, br, j;
    logic [2:0]  ac;
    logic [31:0] opb, res, rdat, wb;
    int          idx;
    instr = ins; rs_data = a; rt_data = b;
    #2;
    k  = classify(ins);
    rd = (k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT});
    rw = rd || k == K_LW || k == K_ADDI;
    as = (k inside {K_LW, K_SW, K_ADDI});
    mr = (k == K_LW);
    mw = (k == K_SW);
    m2r = (k == K_LW);
    br = (k == K_BEQ);
    j  = (k == K_J);
    opb = as ? 32'(signed'(ins[15:0])) : b;
    case (k)
      K_SUB, K_BEQ: begin ac = 3'b110; res = a - opb; end
      K_AND:        begin ac = 3'b000; res = a & opb; end
      K_OR:         begin ac = 3'b001; res = a | opb; end
      K_SLT:        begin ac = 3'b111; res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0; end
      default:      begin ac = 3'b010; res = a + opb; end
    endcase
    idx  = int'((res >> 2) % 256);
    rdat = mr ? ref_mem[idx] : 32'd0;
    wb   = m2r ? rdat : res;
    check({name, ".ctl"}, {21'd0, reg_dst, reg_write, alu_src, mem_read, mem_write,
                            mem_to_reg, branch, jump, alu_control},
          {21'd0, rd, rw, as, mr, mw, m2r, br, j, ac});
    check({name, ".alu"}, alu_result, res);
    check({name, ".zero"}, {31'd0, zero}, {31'd0, res == 32'd0});
    check({name, ".rdata"}, mem_rdata, rdat);
    check({name, ".wb"}, wb_data, wb);
    $display("txn %-10s instr=%h a=%h b=%h alu=%h rdata=%h", name, ins, a, b, alu_result, mem_rdata);
    pend_we = mw; pend_idx = idx; pend_data = b;
  endtask

  task automatic commit();
    @(posedge clk);
    if (pend_we && rst) ref_mem[pend_idx] = pend_data;
    pend_we = 1'b0;
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    pend_we = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{rtype(6'h20), 32'd7, 32'd5, 11'b11000000010, 32'd12, 1'b0};
    vecs[1]  = '{rtype(6'h22), 32'd5, 32'd7, 11'b11000000110, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{rtype(6'h24), 32'hF0F0, 32'h0FF0, 11'b11000000000, 32'h00F0, 1'b0};
    vecs[3]  = '{rtype(6'h25), 32'hF0F0, 32'h0FF0, 11'b11000000001, 32'hFFF0, 1'b0};
    vecs[4]  = '{rtype(6'h2A), 32'hFFFFFFFF, 32'd1, 11'b11000000111, 32'd1, 1'b0};
    vecs[5]  = '{rtype(6'h2A), 32'd1, 32'hFFFFFFFF, 11'b11000000111, 32'd0, 1'b1};
    vecs[6]  = '{itype(6'h08, 16'hFFFC), 32'd10, 32'd99, 11'b01100000010, 32'd6, 1'b0};
    vecs[7]  = '{itype(6'h04, 16'h0003), 32'd9, 32'd9, 11'b00000010110, 32'd0, 1'b1};
    vecs[8]  = '{{6'h02, 26'h123}, 32'd3, 32'd4, 11'b00000001010, 32'd7, 1'b0};
    vecs[9]  = '{itype(6'h3F, 16'h0010), 32'd1, 32'd2, 11'b00000000010, 32'd3, 1'b0};
    vecs[10] = '{rtype(6'h3F), 32'd1, 32'd2, 11'b00000000010, 32'd3, 1'b0};
    vecs[11] = '{rtype(6'h20), 32'hFFFFFFFF, 32'd1, 11'b11000000010, 32'd0, 1'b1};

    instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0; pend_we = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Reset state read-back
    apply("reset_lw", 32'h8C000010, 32'd0, 32'd0);
    check("reset.rdata", mem_rdata, 32'd0);
    check("reset.wb", wb_data, 32'd0);
    check("reset.m2r", {31'd0, mem_to_reg}, 32'd1);
    check("reset.alu", alu_result, 32'h10);
    commit();

    for (int i = 0; i < 12; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].ins, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d.tctl", i), {21'd0, reg_dst, reg_write, alu_src, mem_read,
            mem_write, mem_to_reg, branch, jump, alu_control}, {21'd0, vecs[i].ctl});
      check($sformatf("vec%0d.tres", i), alu_result, vecs[i].res);
      check($sformatf("vec%0d.tzero", i), {31'd0, zero}, {31'd0, vecs[i].z});
      commit();
    end

    // Store then load, byte-offset and high-bit aliasing
    apply("sw", itype(6'h2B, 16'h0004), 32'h100, 32'hDEADBEEF);
    check("sw.rdata_before", mem_rdata, 32'd0);
    commit();
    apply("lw", itype(6'h23, 16'h0004), 32'h100, 32'd0);
    check("lw.rdata", mem_rdata, 32'hDEADBEEF);
    check("lw.wb", wb_data, 32'hDEADBEEF);
    commit();
    apply("lw_107", itype(6'h23, 16'h0007), 32'h100, 32'd0);
    check("lw_107.rdata", mem_rdata, 32'hDEADBEEF);
    commit();
    apply("lw_504", itype(6'h23, 16'h0004), 32'h500, 32'd0);
    check("lw_504.rdata", mem_rdata, 32'hDEADBEEF);
    commit();

    // Illegal encodings must not write memory
    apply("bad_op", itype(6'h3F, 16'h0104), 32'h0, 32'h12345678);
    commit();
    apply("bad_fn", rtype(6'h3F), 32'h100, 32'h4);
    commit();
    apply("lw_after_bad", itype(6'h23, 16'h0104), 32'h0, 32'd0);
    check("bad.unchanged", mem_rdata, 32'hDEADBEEF);
    commit();

    // Reset pulsed between edges clears a written word
    apply("sw_w3", itype(6'h2B, 16'h000C), 32'h0, 32'hAAAA5555);
    commit();
    apply("lw_w3", itype(6'h23, 16'h000C), 32'h0, 32'd0);
    check("w3.written", mem_rdata, 32'hAAAA5555);
    rst = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    apply("lw_w3_rst", itype(6'h23, 16'h000C), 32'h0, 32'd0);
    check("w3.cleared", mem_rdata, 32'd0);
    check("lw_104.cleared", 32'd0, mem_rdata | 32'd0);
    commit();

    // Reset held across a store edge: write lost, combinational path still live
    apply("sw_w5", itype(6'h2B, 16'h0014), 32'h0, 32'h5A5A5A5A);
    rst = 1'b0;
    model_reset();
    commit();
    apply("add_in_rst", rtype(6'h20), 32'd7, 32'd5);
    check("rst.alu_live", alu_result, 32'd12);
    rst = 1'b1;
    commit();
    apply("lw_w5", itype(6'h23, 16'h0014), 32'h0, 32'd0);
    check("w5.lost", mem_rdata, 32'd0);
    commit();

    // Randomized mix against the model
    for (int n = 0; n < 300; n++) begin
      int          k;
      logic [31:0] ins, a, b;
      k = $urandom_range(0, 10);
      a = $urandom(); b = $urandom();
      case (k)
        0:  ins = rtype(6'h20);
        1:  ins = rtype(6'h22);
        2:  ins = rtype(6'h24);
        3:  ins = rtype(6'h25);
        4:  ins = rtype(6'h2A);
        5:  begin ins = itype(6'h23, 16'($urandom_range(0, 63) * 4)); a = $urandom_range(0, 1023); end
        6:  begin ins = itype(6'h2B, 16'($urandom_range(0, 63) * 4)); a = $urandom_range(0, 1023); end
        7:  begin ins = itype(6'h04, 16'($urandom())); if (n % 3 == 0) b = a; end
        8:  ins = itype(6'h08, 16'($urandom()));
        9:  ins = {6'h02, 26'($urandom())};
        default: ins = {6'($urandom_range(0, 63)), 26'($urandom())};
      endcase
      apply($sformatf("rnd%0d", n), ins, a, b);
      commit();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
